// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment constants and hex decode for the scan driver
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction
endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot counter, digit index, frame-boundary pulse and blank window
module seg7_scan_timer #(
  parameter int NUM_DIGITS = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 2,
  localparam int IW = $clog2(NUM_DIGITS) < 1 ? 1 : $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx,
  output logic          boundary,
  output logic          frame_done,
  output logic          blank
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt;
  logic last_cnt, last_idx;
  assign last_cnt = cnt == CW'(REFRESH_DIV - 1);
  assign last_idx = idx == IW'(NUM_DIGITS - 1);
  assign boundary = last_cnt && last_idx;
  assign blank = cnt < CW'(BLANK_CYCLES);
  // idx wraps explicitly so non-power-of-two digit counts never reach unused codes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt <= last_cnt ? '0 : cnt + 1'b1;
      idx <= last_cnt ? (last_idx ? '0 : idx + 1'b1) : idx;
      frame_done <= boundary;
    end
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode hex display driver with double-buffered
// data, per-digit enable, decimal points, leading-zero blanking and a frame strobe
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int IW = $clog2(NUM_DIGITS) < 1 ? 1 : $clog2(NUM_DIGITS);
  logic [IW-1:0] idx;
  logic boundary, blank;
  logic [4*NUM_DIGITS-1:0] act_value, pend_value;
  logic [NUM_DIGITS-1:0] act_dp, act_en, pend_dp, pend_en;
  logic pend_valid, upper_zero, hidden;
  logic [3:0] nib;

  seg7_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .idx(idx),
    .boundary(boundary),
    .frame_done(frame_done),
    .blank(blank)
  );

  // swap reads pending before this edge's load lands, so a boundary load waits a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      act_value <= '0;
      act_dp <= '0;
      act_en <= '0;
      pend_value <= '0;
      pend_dp <= '0;
      pend_en <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (boundary && pend_valid) begin
        act_value <= pend_value;
        act_dp <= pend_dp;
        act_en <= pend_en;
      end
      if (load) begin
        pend_value <= value;
        pend_dp <= dp;
        pend_en <= digit_en;
      end
      pend_valid <= load || (pend_valid && !boundary);
    end
  end

  assign nib = act_value[idx*4 +: 4];

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(idx) && act_value[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    hidden = !act_en[idx] || (blank_lz && idx != '0 && upper_zero && !act_dp[idx]);
  end

  always_ff @(posedge clk) begin
    if (rst || blank || hidden) begin
      seg <= SEG_BLANK;
      dp_n <= 1'b1;
      an <= '1;
    end else begin
      seg <= hex_to_seg(nib);
      dp_n <= !act_dp[idx];
      an <= ~(NUM_DIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scenarios plus random traffic against a cycle-count reference model
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp = '0, digit_en = '0, an;
  logic [6:0] seg;
  logic dp_n, frame_done;
  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] a_val = '0, p_val = '0;
  logic [3:0] a_dp = '0, a_en = '0, p_dp = '0, p_en = '0;
  bit p_valid = 0;
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .digit_en(digit_en), .load(load),
    .blank_lz(blank_lz), .seg(seg), .dp_n(dp_n), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // expectation comes from the cycle count since reset: slot = cyc/R, position = cyc%R
  task automatic tick();
    int d, pos;
    bit bnd, vis, upz, r, l, lz;
    logic [15:0] v;
    logic [3:0] vd, ve, e_an;
    logic [6:0] e_seg;
    logic e_dpn, e_fd;
    r = rst; l = load; lz = blank_lz; v = value; vd = dp; ve = digit_en;
    pos = cyc % R;
    d = (cyc / R) % N;
    bnd = (cyc % (R * N)) == R * N - 1;
    upz = 1;
    for (int j = d; j < N; j++) if (((a_val >> (4 * j)) & 16'hF) != 0) upz = 0;
    vis = pos >= B && a_en[d] && !(lz && d != 0 && upz && !a_dp[d]);
    e_an = vis ? ~(4'b0001 << d) : 4'hF;
    e_seg = vis ? seg_tab[(a_val >> (4 * d)) & 16'hF] : 7'h7F;
    e_dpn = vis ? !a_dp[d] : 1'b1;
    e_fd = bnd;
    if (r) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0;
    end
    @(posedge clk);
    #1;
    if (r) begin
      cyc = 0; a_val = '0; a_dp = '0; a_en = '0; p_val = '0; p_dp = '0; p_en = '0; p_valid = 0;
    end else begin
      if (bnd && p_valid) begin
        a_val = p_val; a_dp = p_dp; a_en = p_en; p_valid = 0;
      end
      if (l) begin
        p_val = v; p_dp = vd; p_en = ve; p_valid = 1;
      end
      cyc++;
    end
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp_n", dp_n, e_dpn);
    check("frame_done", frame_done, e_fd);
    check("an_onehot", $countones(~an) <= 1, 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    value = v; dp = d; digit_en = e; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic run_until(input int phase);
    for (int k = 0; k < R * N && (cyc % (R * N)) != phase; k++) tick();
  endtask

  initial begin
    logic [15:0] m;
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    do_load(16'h12AF, 4'b0000, 4'hF);
    run(48);
    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0000, 4'hF);
    run(40);
    blank_lz = 1'b0;
    run(32);
    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0100, 4'hF);
    run(40);
    blank_lz = 1'b0;
    run_until(2);
    do_load(16'h1111, 4'b0000, 4'hF);
    run(3);
    do_load(16'h2222, 4'b0000, 4'hF);
    run_until(15);
    do_load(16'h3333, 4'b0000, 4'hF);
    run(40);
    run_until(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(40);
    do_load(16'h9C4E, 4'b0011, 4'b1010);
    run(48);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rst = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: m = 16'h000F;
          1: m = 16'h00FF;
          2: m = 16'h0FFF;
          default: m = 16'hFFFF;
        endcase
        do_load(16'($urandom) & m, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom));
      end else tick();
    end
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed hex driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus. It replaces per-digit static decoding with anode scanning and double-buffered display data. It adds leading-zero blanking, per-digit enable, decimal points, anti-ghosting blanking and a frame strobe. It sits between register/switch logic and the board display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
REFRESH_DIV, 100000, clk cycles each digit is driven per scan slot (>=2)
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; must satisfy BLANK_CYCLES < REFRESH_DIV

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, where digit 0 is the rightmost digit
dp  in  NUM_DIGITS  decimal point request per digit, active high
digit_en  in  NUM_DIGITS  per-digit enable, active high
load  in  1  one-cycle strobe that captures value, dp and digit_en into the pending buffer
blank_lz  in  1  leading-zero blanking enable; sampled live, not buffered
seg  out  7  segments {g,f,e,d,c,b,a}, active low
dp_n  out  1  decimal point, active low
an  out  NUM_DIGITS  anode selects, active low, at most one low at any time
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset:
  - seg = 7'b1111111, dp_n = 1, an = all ones, frame_done = 0.
  - Slot counter cnt = 0, digit index idx = 0.
  - Active buffer cleared: value = 0, dp = 0, digit_en = 0. Pending buffer cleared, pending_valid = 0.
  - The display stays dark until the first load has been swapped in.
- Reset asserted mid-scan aborts the current slot immediately. The next cycle shows the reset values above.
- Scan timing:
  - cnt counts 0..REFRESH_DIV-1 and wraps.
  - At cnt == REFRESH_DIV-1, idx advances by 1, wrapping from NUM_DIGITS-1 to 0.
  - The idx wrap is the frame boundary.
- Frame boundary:
  - frame_done = 1 for exactly one cycle, in the cycle after the wrap.
  - If pending_valid, pending is copied to active and pending_valid is cleared in the same edge.
- load:
  - Writes pending and sets pending_valid.
  - Repeated loads within one frame: the last one wins.
  - load coinciding with the boundary edge: the swap uses the pre-load pending contents. The new data stays pending with pending_valid = 1.
  - load with pending_valid = 0 at the boundary edge is not swapped in until the next frame.
- Visibility of digit i (all from active data, except blank_lz which is live):
  - A digit is hidden if digit_en[i] = 0.
  - A digit is also hidden if blank_lz = 1, i != 0, nibble i == 0, every higher nibble == 0, and dp[i] = 0.
  - Digit 0 is never blanked by blank_lz.
- Outputs are registered, with latency 1 cycle from the (cnt, idx) state.
  - If cnt < BLANK_CYCLES or the digit is hidden: an = all ones, seg = 7'b1111111, dp_n = 1.
  - Otherwise: an = ~(1 << idx), seg = decode(nibble idx), dp_n = ~dp[idx].
- Decode table, active low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Width rules:
  - cnt is $clog2(REFRESH_DIV) bits.
  - idx is $clog2(NUM_DIGITS) bits, minimum 1.
  - When NUM_DIGITS is not a power of two, idx must wrap explicitly at NUM_DIGITS-1.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'b1111111
  - the 16-entry hex segment constant array
  - function hex_to_seg(nibble)
- One sub-module, seg7_scan_timer, holds cnt, idx, the frame-boundary pulse and the blank-window flag.
- Top level holds buffers, visibility logic and the output registers.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
1. Reset, then load value=16'h12AF, digit_en=4'hF, dp=0 -> after the first frame_done, each slot shows 1 blank cycle, then an=1110 seg=0001110 (F), an=1101 seg=0001000 (A), an=1011 seg=0100100 (2), an=0111 seg=1111001 (1); never more than one an bit low.
2. load value=16'h0005, blank_lz=1 -> only an=1110 ever goes low, seg=0010010; with blank_lz=0, digits 1..3 show 1000000.
3. Same as 2 with dp=4'b0100 -> digit 2 shows seg=1000000, dp_n=0; digit 3 stays blanked.
4. load 16'h1111, then load 16'h2222 in the same frame, then load 16'h3333 on the boundary cycle -> next frame shows 2222, the frame after shows 3333; 1111 is never displayed.
5. Assert rst during slot 2 -> the next cycle shows an=1111, seg=1111111, frame_done=0; the display stays dark until a new load plus a frame boundary.
6. digit_en=4'b1010 -> an bits 0 and 2 stay high; frame_done pulses every 16 cycles.
